// File: rtl/ten_meter_pulse_gen.sv
// Taximeter distance front end: synchronises and debounces the wheel sensor,
// emits a strobe every pulses_per_10m accepted rising edges and flags motion.
module ten_meter_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STALL_CYCLES    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wheel_in,
  input  logic       en,
  input  logic [7:0] pulses_per_10m,
  output logic       ten_meter_pulse,
  output logic       moving,
  output logic [7:0] wheel_cnt
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]     STALL   = 24'(STALL_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } db_state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  db_state_t              r_state;
  logic [CW-1:0]          r_stab_cnt;
  logic                   r_event;
  logic [7:0]             w_lim;
  logic [23:0]            r_timer;
  logic [23:0]            w_timer_nxt;

  // Metastability guard; nothing downstream sees wheel_in before the last flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], wheel_in};
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Counter counts matching cycles; the D-th match commits the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= STABLE_LOW;
      r_stab_cnt <= '0;
      r_event    <= 1'b0;
    end else begin
      r_event <= 1'b0;
      case (r_state)
        STABLE_LOW: begin
          if (w_synced) begin
            r_state    <= CHECK_HIGH;
            r_stab_cnt <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!w_synced) begin
            r_state <= STABLE_LOW;
          end else if (r_stab_cnt == DB_LAST) begin
            r_state <= STABLE_HIGH;
            r_event <= 1'b1;
          end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!w_synced) begin
            r_state    <= CHECK_LOW;
            r_stab_cnt <= '0;
          end
        end
        CHECK_LOW: begin
          if (w_synced) begin
            r_state <= STABLE_HIGH;
          end else if (r_stab_cnt == DB_LAST) begin
            r_state <= STABLE_LOW;
          end else begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= STABLE_LOW;
          r_stab_cnt <= '0;
        end
      endcase
    end
  end

  // >= rather than == so a lowered pulses_per_10m fires on the next edge.
  assign w_lim = (pulses_per_10m == 8'd0) ? 8'd0 : pulses_per_10m - 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wheel_cnt       <= 8'd0;
      ten_meter_pulse <= 1'b0;
    end else begin
      ten_meter_pulse <= 1'b0;
      if (r_event && en) begin
        if (wheel_cnt >= w_lim) begin
          wheel_cnt       <= 8'd0;
          ten_meter_pulse <= 1'b1;
        end else begin
          wheel_cnt <= wheel_cnt + 8'd1;
        end
      end
    end
  end

  assign w_timer_nxt = r_event          ? 24'd0 :
                       (r_timer >= STALL) ? STALL : r_timer + 24'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= STALL;
      moving  <= 1'b0;
    end else begin
      r_timer <= w_timer_nxt;
      moving  <= (w_timer_nxt < STALL);
    end
  end

endmodule

// File: doc/ten_meter_pulse_gen.md
TEN_METER_PULSE_GEN -- requirements
Module: ten_meter_pulse_gen

Interface
- REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count on wheel_in, legal range 2..4.
- REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a level change, legal range 1..65535.
- REQ-003 SHALL have parameter STALL_CYCLES, default 50000: cycles without an accepted wheel edge before the vehicle counts as stopped, legal range 1..2^24-1.
- REQ-004 SHALL have port clk, input, 1, the single system clock; all state rising-edge clocked.
- REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
- REQ-006 SHALL have port wheel_in, input, 1, raw wheel-rotation sensor level; asynchronous and bouncy.
- REQ-007 SHALL have port en, input, 1, meter engaged; distance counting is allowed only while high.
- REQ-008 SHALL have port pulses_per_10m, input, 8, wheel edges per 10 m; value 0 is treated as 1.
- REQ-009 SHALL have port ten_meter_pulse, output, 1, single-cycle strobe per 10 m travelled; feeds the distance fare stage.
- REQ-010 SHALL have port moving, output, 1, high while wheel edges arrive within STALL_CYCLES; feeds the waiting-time fare stage.
- REQ-011 SHALL have port wheel_cnt, output, 8, current wheel-edge count within the present 10 m segment.

Function
- REQ-012 SHALL pass wheel_in through SYNC_STAGES flops before any other use.
- REQ-013 SHALL debounce with a 4-state FSM: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
- REQ-014 STABLE_LOW -> CHECK_HIGH when the synced input is 1; STABLE_HIGH -> CHECK_LOW when it is 0; a stability counter clears on entry to a CHECK state.
- REQ-015 In a CHECK state, each cycle the synced input matches the target level SHALL increment the counter; reaching DEBOUNCE_CYCLES SHALL move to the target STABLE state; any mismatch SHALL return to the originating STABLE state.
- REQ-016 A CHECK_HIGH -> STABLE_HIGH transition SHALL generate one internal wheel event; falling transitions generate none.
- REQ-017 On a wheel event with en=1: if wheel_cnt >= max(pulses_per_10m,1)-1, wheel_cnt SHALL go to 0 and ten_meter_pulse SHALL be high for exactly the next cycle; otherwise wheel_cnt SHALL increment.
- REQ-018 With en=0, wheel events SHALL NOT change wheel_cnt or assert ten_meter_pulse; wheel_cnt SHALL hold its value.
- REQ-019 A decrease of pulses_per_10m below wheel_cnt+1 SHALL take effect at the next wheel event (fire and clear per REQ-017); no spontaneous pulse.
- REQ-020 Latency from the first clk edge sampling a stable wheel_in=1 to ten_meter_pulse high SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
- REQ-021 A stall timer (24 bit) SHALL clear on every wheel event regardless of en, otherwise increment, saturating at STALL_CYCLES.
- REQ-022 moving SHALL be registered as (timer < STALL_CYCLES).
- REQ-023 ten_meter_pulse SHALL never be high on two consecutive cycles; min spacing is 2*DEBOUNCE_CYCLES cycles.

Reset
- REQ-024 While rst=1, the FSM SHALL be in STABLE_LOW, all sync flops 0, stability counter 0, wheel_cnt 0, ten_meter_pulse 0, stall timer = STALL_CYCLES, moving 0.
- REQ-025 Reset asserted mid-segment or mid-CHECK SHALL discard partial progress; first wheel event after release counts as edge 1.

Verification (DEBOUNCE_CYCLES=4, STALL_CYCLES=100, SYNC_STAGES=2)
- REQ-026 en=1, pulses_per_10m=3, 9 clean wheel_in pulses (20 high / 20 low cycles) -> exactly 3 ten_meter_pulse strobes, one each after edges 3, 6, 9; each 1 cycle, 7 cycles after the wheel_in rise.
- REQ-027 Glitches of wheel_in high for 3 cycles, repeated 10 times -> no wheel event, wheel_cnt stays 0, no strobe, moving stays 0.
- REQ-028 en=0 for 5 clean pulses, then en=1 with pulses_per_10m=2 for 2 pulses -> wheel_cnt 0 during en=0, strobe on the 2nd pulse after en rises, moving=1 during all pulses.
- REQ-029 pulses_per_10m=0, 4 clean pulses -> 4 strobes; wheel_cnt stays 0.
- REQ-030 After the last wheel event, no further edges -> moving falls exactly 100 cycles later (registered); next accepted edge returns moving to 1 one cycle after the event.
- REQ-031 rst pulsed while wheel_cnt=2 with pulses_per_10m=3 -> all outputs at reset values immediately (async); 3 further pulses are needed for the next strobe.
